// File: rtl/qmc_pkg.sv
// Shared fixed-point definitions for the QMC sampler blocks (Q16.16 datapath).
package qmc_pkg;
    localparam int WIDTH        = 32;
    localparam int QINT         = 16;
    localparam int QFRAC        = 16;
    localparam int CDF_SEG_BITS = 6;
    localparam int KNOT_BITS    = 17;

    localparam logic [31:0] ONE     = 32'h0001_0000;
    localparam logic [31:0] Z_CLAMP = 32'h0008_0000;

    typedef logic signed [WIDTH-1:0] fx_t;
endpackage

// File: rtl/normal_cdf_rom.sv
// Dual-read knot table: knot[i] = round(Phi(i*0.125)*65536), registered reads held by en.
module normal_cdf_rom
    import qmc_pkg::*;
#(
    parameter int SEG_BITS = CDF_SEG_BITS
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [SEG_BITS-1:0]  addr_lo,
    input  logic [SEG_BITS:0]    addr_hi,
    output logic [KNOT_BITS-1:0] knot_lo,
    output logic [KNOT_BITS-1:0] knot_hi
);

    function automatic logic [KNOT_BITS-1:0] knot_value(input logic [SEG_BITS:0] idx);
        logic [KNOT_BITS-1:0] v;
        case (int'(idx))
            0:  v = 17'd32768;  1:  v = 17'd36028;  2:  v = 17'd39237;  3:  v = 17'd42347;
            4:  v = 17'd45316;  5:  v = 17'd48104;  6:  v = 17'd50684;  7:  v = 17'd53033;
            8:  v = 17'd55138;  9:  v = 17'd56997;  10: v = 17'd58612;  11: v = 17'd59991;
            12: v = 17'd61158;  13: v = 17'd62122;  14: v = 17'd62911;  15: v = 17'd63544;
            16: v = 17'd64045;  17: v = 17'd64435;  18: v = 17'd64735;  19: v = 17'd64961;
            20: v = 17'd65129;  21: v = 17'd65252;  22: v = 17'd65341;  23: v = 17'd65404;
            24: v = 17'd65448;  25: v = 17'd65478;  26: v = 17'd65498;  27: v = 17'd65512;
            28: v = 17'd65521;  29: v = 17'd65527;  30: v = 17'd65530;  31: v = 17'd65533;
            32: v = 17'd65534;  33: v = 17'd65535;  34: v = 17'd65535;
            // Beyond |z| = 4.25 the tail is below half an LSB.
            default: v = 17'd65536;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (en) begin
            knot_lo <= knot_value({1'b0, addr_lo});
            knot_hi <= knot_value(addr_hi);
        end
    end

endmodule

// File: rtl/normal_cdf.sv
// Pipelined forward standard-normal CDF: signed Q16.16 z in, Q16.16 Phi(z) out, 4-cycle latency.
module normal_cdf
    import qmc_pkg::*;
#(
    parameter int WIDTH    = qmc_pkg::WIDTH,
    parameter int QINT     = qmc_pkg::QINT,
    parameter int QFRAC    = qmc_pkg::QFRAC,
    parameter int SEG_BITS = CDF_SEG_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] z_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] u_out
);

    localparam int IW  = QINT + QFRAC;
    localparam int A_W = QFRAC + 4;
    localparam int F_W = QFRAC + 3 - SEG_BITS;
    localparam int P_W = KNOT_BITS + F_W + 1;

    // Handshake: a beat moves when valid && ready at a posedge; the whole pipe
    // advances together whenever the output slot is empty or being drained.
    logic en;
    assign en        = !valid_out || ready_in;
    assign ready_out = en;

    logic [IW-1:0]  mag;
    logic [A_W-1:0] a_sat;
    assign mag   = z_in[WIDTH-1] ? IW'((~z_in) + WIDTH'(1)) : IW'(z_in);
    assign a_sat = (mag >= IW'(Z_CLAMP)) ? A_W'(Z_CLAMP) : mag[A_W-1:0];

    logic                v0, v1, v2, v3;
    logic                s0_sign, s1_sign, s2_sign, s3_sign;
    logic [A_W-1:0]      s0_a;
    logic [SEG_BITS-1:0] s1_k;
    logic [F_W:0]        s1_f, s2_f;
    logic [KNOT_BITS-1:0] knot_lo, knot_hi, s3_base;
    logic [P_W-1:0]      s3_prod;

    logic end_pt;
    assign end_pt = s0_a[A_W-1];

    normal_cdf_rom #(.SEG_BITS(SEG_BITS)) u_rom (
        .clk     (clk),
        .en      (en),
        .addr_lo (s1_k),
        .addr_hi ({1'b0, s1_k} + (SEG_BITS+1)'(1)),
        .knot_lo (knot_lo),
        .knot_hi (knot_hi)
    );

    logic [KNOT_BITS-1:0] delta;
    assign delta = knot_hi - knot_lo;

    logic [WIDTH-1:0] p_full, u_full;
    logic [QFRAC-1:0] u_sat;
    assign p_full = WIDTH'(s3_base)
                  + WIDTH'((s3_prod + P_W'(1 << (F_W - 1))) >> F_W);
    assign u_full = s3_sign ? (WIDTH'(ONE) - p_full) : p_full;
    assign u_sat  = u_full[WIDTH-1]          ? '0 :
                    (|u_full[WIDTH-2:QFRAC]) ? '1 : u_full[QFRAC-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            s0_sign <= 1'b0; s1_sign <= 1'b0; s2_sign <= 1'b0; s3_sign <= 1'b0;
            s0_a    <= '0;
            s1_k    <= '0;
            s1_f    <= '0;
            s2_f    <= '0;
            s3_base <= '0;
            s3_prod <= '0;
            valid_out <= 1'b0;
            u_out     <= '0;
        end else if (en) begin
            v0      <= valid_in;
            s0_sign <= z_in[WIDTH-1];
            s0_a    <= a_sat;
            // The 8.0 endpoint lands on the last segment with a full fraction.
            v1      <= v0;
            s1_sign <= s0_sign;
            s1_k    <= end_pt ? '1 : s0_a[A_W-2 -: SEG_BITS];
            s1_f    <= end_pt ? {1'b1, {F_W{1'b0}}} : {1'b0, s0_a[F_W-1:0]};
            v2      <= v1;
            s2_sign <= s1_sign;
            s2_f    <= s1_f;
            v3      <= v2;
            s3_sign <= s2_sign;
            s3_base <= knot_lo;
            s3_prod <= P_W'(delta) * P_W'(s2_f);
            valid_out <= v3;
            u_out     <= {{(WIDTH-QFRAC){1'b0}}, u_sat};
        end
    end

endmodule

// File: tb/tb_normal_cdf.sv
// Bench for normal_cdf: directed table points, back-pressure, reset flush and random traffic.
module tb_normal_cdf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b1;
    logic [31:0] z_in = '0;
    logic        ready_out, valid_out;
    logic [31:0] u_out;

    always #5 clk = ~clk;

    normal_cdf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .z_in      (z_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .u_out     (u_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    logic [31:0] exp_q[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_u    = '0;

    int knot_tab [0:64] = '{
        32768, 36028, 39237, 42347, 45316, 48104, 50684, 53033,
        55138, 56997, 58612, 59991, 61158, 62122, 62911, 63544,
        64045, 64435, 64735, 64961, 65129, 65252, 65341, 65404,
        65448, 65478, 65498, 65512, 65521, 65527, 65530, 65533,
        65534, 65535, 65535, 65536, 65536, 65536, 65536, 65536,
        65536, 65536, 65536, 65536, 65536, 65536, 65536, 65536,
        65536, 65536, 65536, 65536, 65536, 65536, 65536, 65536,
        65536, 65536, 65536, 65536, 65536, 65536, 65536, 65536,
        65536 };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: Phi(|z|) by linear interpolation between 0.125-spaced knots, then fold.
    function automatic logic [31:0] model_cdf(input logic [31:0] z);
        longint mag, k, f, p, u;
        mag = z[31] ? (longint'(1) << 32) - longint'(z) : longint'(z);
        if (mag > 8 * 65536) mag = 8 * 65536;
        k = mag / 8192;
        f = mag % 8192;
        if (k >= 64) p = knot_tab[64];
        else p = knot_tab[k] + ((knot_tab[k+1] - knot_tab[k]) * f + 4096) / 8192;
        u = z[31] ? 65536 - p : p;
        if (u < 0) u = 0;
        if (u > 65535) u = 65535;
        return 32'(u);
    endfunction

    // Scoreboard: accepted samples are queued, every drained result is popped in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(valid_out), 1);
                check("hold_data", u_out, prev_u);
            end
            if (valid_out && !ready_in) check("stall_ready_low", 32'(ready_out), 0);
            if (valid_out && ready_in) begin
                check("sb_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("data", u_out, exp_q.pop_front());
                n_out++;
            end
            if (valid_in && ready_out) exp_q.push_back(model_cdf(z_in));
            prev_hold = valid_out && !ready_in;
            prev_u    = u_out;
        end
    end

    task automatic send(input logic [31:0] z);
        int guard = 0;
        valid_in = 1'b1;
        z_in     = z;
        @(negedge clk);
        while (!ready_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready", 32'(ready_out), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] z, input logic [31:0] expv);
        int lat = 0;
        send(z);
        valid_in = 1'b0;
        while (!valid_out && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 4);
        check(tag, u_out, expv);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        ready_in = 1'b1;
        while ((exp_q.size() != 0 || valid_out) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_done", 32'(exp_q.size()), 0);
    endtask

    logic [31:0] specials [0:4] = '{32'h0000_0000, 32'h8000_0000, 32'h0008_0000,
                                    32'hFFF8_0000, 32'h7FFF_FFFF};
    bit rand_done;

    initial begin
        int base;
        #1;
        check("reset_valid_out", 32'(valid_out), 0);
        check("reset_u_out", u_out, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("ready_after_reset", 32'(ready_out), 1);

        run_one("zero",       32'h0000_0000, 32768);
        run_one("plus_one",   32'h0001_0000, 55138);
        run_one("minus_one",  32'hFFFF_0000, 10398);
        run_one("mid_seg0",   32'h0000_1000, 34398);
        run_one("clamp_p16",  32'h0010_0000, 65535);
        run_one("clamp_min",  32'h8000_0000, 0);
        run_one("endpoint_8", 32'h0008_0000, 65535);
        run_one("endpoint_m8", 32'hFFF8_0000, 0);

        // Back-pressure: 8 back-to-back samples, ready_in low for cycles 5..9 after first accept.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'(i * 32'h0000_3000) - 32'h0000_C000);
                valid_in = 1'b0;
            end
            begin
                int g = 0;
                @(negedge clk);
                while (!(valid_in && ready_out) && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                @(posedge clk);
                repeat (4) @(posedge clk);
                #1 ready_in = 1'b0;
                repeat (5) @(posedge clk);
                #1 ready_in = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(n_out - base), 8);

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) send(32'h0000_8000 + 32'(i) * 32'h0001_0000);
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(valid_out), 0);
        check("rst_mid_u", u_out, 0);
        exp_q.delete();
        prev_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 check("no_stale_out", 32'(valid_out), 0);
        end
        run_one("post_reset", 32'h0001_0000, 55138);

        // Random traffic with random back-pressure.
        base = n_out;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [31:0] z;
                    case ($urandom_range(0, 3))
                        0: z = $urandom;
                        1: z = 32'(int'($urandom_range(0, 18 * 65536)) - 9 * 65536);
                        2: z = 32'((int'($urandom_range(0, 128)) - 64) * 8192);
                        default: z = specials[$urandom_range(0, 4)];
                    endcase
                    send(z);
                    if ($urandom_range(0, 3) == 0) begin
                        valid_in = 1'b0;
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                end
                valid_in = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        check("rand_count", 32'(n_out - base), 200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/normal_cdf.md
# normal_cdf

Pipelined forward standard-normal CDF: maps a signed Q16.16 sample z to u = Φ(z) in Q16.16 [0,1). It is the inverse direction of the inverse-CDF stage. Its first uses are re-uniformising path shocks for the QMC-LSM consistency checks and the round-trip self-test of the sampler. It uses the same valid/ready handshake naming as the inverse-CDF block, so the two can be chained back to back.

## Interface
Parameters:
- WIDTH, 32, data word width (signed two's complement).
- QINT, 16, integer bits of the input format.
- QFRAC, 16, fractional bits of the input and output formats.
- SEG_BITS, 6, log2 of the interpolation segments over |z| in [0,8); segment width is 8/2^SEG_BITS = 0.125.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  upstream has a sample on z_in.
- ready_out  out  1  block accepts a sample this cycle.
- z_in  in  WIDTH  signed Q16.16 normal sample.
- valid_out  out  1  u_out holds a result.
- ready_in  in  1  downstream accepts u_out this cycle.
- u_out  out  WIDTH  Q16.16 probability; the upper 16 bits are always 0, and the range is 0x0000_0000..0x0000_FFFF.

## Operation
- Symmetry: Φ(z) = 1 − Φ(|z|) for z < 0. Compute the positive-side value p, then fold.
- Stage S0: register sign = z_in[WIDTH-1] and a = |z_in|.
  - Saturate a to 0x0008_0000 (8.0) when |z_in| ≥ 8.0 or z_in = 0x8000_0000.
- Stage S1:
  - Segment index k = a[18:13] (SEG_BITS bits); fraction f = a[12:0] (13 bits).
  - When a = 8.0: k = 63, f = 8191 + 1, treated as the endpoint, i.e. output knot[64].
  - Register the ROM lookups knot[k] and knot[k+1].
- Knot ROM: 65 entries of 17-bit unsigned knot[i] = round(Φ(i·0.125)·65536).
  - knot[0] = 32768, knot[1] = 36028, knot[8] = 55138, knot[64] = 65536.
- Stage S2: delta = knot[k+1] − knot[k] (always ≥ 0, ≤ 16 bits). Register prod = delta·f (29 bits).
- Stage S3: p = knot[k] + ((prod + 4096) >> 13), rounding half-up.
  - u = sign ? 65536 − p : p.
  - Saturate u to [0, 65535].
  - Register the result to u_out.
- Each stage carries a valid bit alongside its data.

## Timing
- Latency: 4 cycles from an accepted input (valid_in && ready_out at edge N) to valid_out = 1 after edge N+4, if not stalled.
- Throughput: one sample per cycle while ready_in = 1.
- Stall: global advance enable en = !valid_out || ready_in; ready_out = en, combinational.
  - When en = 0, every stage register and valid bit holds.
  - u_out and valid_out stay stable while valid_out && !ready_in.
- Bubbles: invalid slots advance like data when en = 1. No bubble collapsing.
- Simultaneous accept and drain in the same cycle is legal and loses no data.
- Reset: all stage valids = 0, u_out = 0, valid_out = 0. ready_out = 1 once reset deasserts.
  - Reset mid-operation discards every in-flight sample. The first output after reset comes from the first post-reset accept.
- Input changes while valid_in && !ready_out are ignored; upstream must hold.

## Structure
- The shared package qmc_pkg holds:
  - WIDTH, QINT, QFRAC defaults;
  - CDF_SEG_BITS;
  - the Q16.16 constants ONE = 0x0001_0000 and Z_CLAMP = 0x0008_0000;
  - a fixed-point typedef fx_t.
- Sub-module normal_cdf_rom is a synchronous dual-read 65×17 ROM with the knots computed offline.
  - It has an enable input tied to en, so it holds under stall.
- The top file holds the pipeline, handshake and fold/saturation logic.

## Test plan
- z_in = 0x0000_0000 -> u_out = 32768 after 4 cycles.
- z_in = 0x0001_0000 (+1.0) -> u_out = 55138; z_in = 0xFFFF_0000 (−1.0) -> u_out = 10398.
- z_in = 0x0000_1000 (0.0625, mid-segment 0) -> u_out = 34398.
- Clamp: z_in = 0x0010_0000 (+16.0) -> 65535; z_in = 0x8000_0000 -> 0; z_in = 0x0008_0000 -> 65535.
- Back-pressure:
  - Stream 8 consecutive samples with ready_in held low for cycles 5–9 after the first accept.
  - Required: u_out and valid_out stable throughout, ready_out = 0 during the stall.
  - Required: all 8 results emerge in order with no loss or duplication.
- Reset mid-stream:
  - Assert rst_n = 0 with 3 samples in flight.
  - Required: valid_out = 0 and u_out = 0 immediately.
  - Required: no stale output after release; the next accepted sample returns after 4 cycles.
